// File: rtl/uart_pkg.sv
// Shared types and constants for the UART16550 transmit path: FSM states,
// line-control field encodings and the parity-bit rule.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam logic [1:0] WL_5 = 2'b00;
  localparam logic [1:0] WL_6 = 2'b01;
  localparam logic [1:0] WL_7 = 2'b10;
  localparam logic [1:0] WL_8 = 2'b11;

  localparam int PAR_EN    = 0;
  localparam int PAR_EVEN  = 1;
  localparam int PAR_STICK = 2;

  // Line-control fields frozen for the duration of one frame.
  typedef struct packed {
    logic [1:0] word_length;
    logic       par_en;
    logic       stop_bits;
  } frame_cfg_t;

  // Parity over the active data bits only; bits above the word length are masked off.
  function automatic logic parity_bit(input logic [7:0] data,
                                      input logic [1:0] wl,
                                      input logic [2:0] par);
    logic [7:0] masked;
    masked = data & (8'hFF >> (2'd3 - wl));
    if (par[PAR_STICK])     return ~par[PAR_EVEN];
    else if (par[PAR_EVEN]) return ^masked;
    else                    return ~^masked;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Host-side handshake between the APB register block and the transmitter:
// THR write strobe/data in, holding-buffer and shifter status out.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       write_flag;
  logic       thr_empty;
  logic       tx_empty;
  logic       tx_overrun;

  modport master (output tx_data, write_flag,
                  input  thr_empty, tx_empty, tx_overrun);
  modport slave  (input  tx_data, write_flag,
                  output thr_empty, tx_empty, tx_overrun);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..period-1 and strobes at the bit end and at the
// half-period point. Shared with the receiver.
module uart_baud_tick #(
  parameter int BAUD_W = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              clear,
  input  logic [BAUD_W-1:0] period,
  output logic              bit_done,
  output logic              half_done
);

  logic [BAUD_W-1:0] cnt;
  logic [BAUD_W-1:0] half;

  assign half      = period >> 1;
  // Periods of 0 and 1 both mean one cycle per bit.
  assign bit_done  = (period <= BAUD_W'(1)) || (cnt == period - BAUD_W'(1));
  assign half_done = (half != '0) && (cnt == half - BAUD_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)                cnt <= '0;
    else if (clear || bit_done)  cnt <= '0;
    else                         cnt <= cnt + BAUD_W'(1);
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: THR holding buffer feeding a TSR shifter and a framing FSM
// (start, 5-8 data bits LSB first, optional parity, 1/1.5/2 stop bits).
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_W = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  uart_tx_if.slave          bus,
  input  logic [1:0]        word_length,
  input  logic [2:0]        parity,
  input  logic              stop_bits,
  input  logic              set_break,
  input  logic [BAUD_W-1:0] baud_rate_cnt,
  output logic              txd
);

  tx_state_t  state, state_next;
  frame_cfg_t cfg;
  logic [7:0] thr_data, shifter, shifter_next;
  logic       thr_full;
  logic [2:0] bit_cnt, bit_cnt_next;
  logic       stop_ext, stop_ext_next;
  logic       par_bit, par_bit_next;
  logic       txd_q, line_next;
  logic       overrun_q;
  logic       load, frame_end, clear;
  logic       bit_done, half_done, half_zero;
  logic [2:0] last_bit;

  assign half_zero = ((baud_rate_cnt >> 1) == '0);
  assign last_bit  = {1'b0, cfg.word_length} + 3'd4;
  assign clear     = load || (state_next != state);

  uart_baud_tick #(.BAUD_W(BAUD_W)) u_tick (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .clear     (clear),
    .period    (baud_rate_cnt),
    .bit_done  (bit_done),
    .half_done (half_done)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next    = state;
    shifter_next  = shifter;
    bit_cnt_next  = bit_cnt;
    stop_ext_next = stop_ext;
    load          = 1'b0;
    frame_end     = 1'b0;
    line_next     = 1'b1;

    case (state)
      ST_IDLE:   if (thr_full) load = 1'b1;
      ST_START:  if (bit_done) state_next = ST_DATA;
      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt == last_bit) begin
            state_next = cfg.par_en ? ST_PARITY : ST_STOP;
          end else begin
            shifter_next = shifter >> 1;
            bit_cnt_next = bit_cnt + 3'd1;
          end
        end
      end
      ST_PARITY: if (bit_done) state_next = ST_STOP;
      ST_STOP: begin
        // stop_ext marks the extra half (5-bit words) or full second stop bit.
        if (!stop_ext) begin
          if (bit_done) begin
            if (!cfg.stop_bits || (cfg.word_length == WL_5 && half_zero)) frame_end = 1'b1;
            else                                                          stop_ext_next = 1'b1;
          end
        end else if (cfg.word_length == WL_5 ? half_done : bit_done) begin
          frame_end = 1'b1;
        end
        if (frame_end) begin
          stop_ext_next = 1'b0;
          if (thr_full) load = 1'b1;
          else          state_next = ST_IDLE;
        end
      end
      default:   state_next = ST_IDLE;
    endcase

    if (load) begin
      state_next    = ST_START;
      shifter_next  = thr_data;
      bit_cnt_next  = '0;
      stop_ext_next = 1'b0;
    end

    par_bit_next = load ? parity_bit(thr_data, word_length, parity) : par_bit;

    // The line register is fed from the next state so txd changes on the same
    // edge that enters the new bit.
    case (state_next)
      ST_START:  line_next = 1'b0;
      ST_DATA:   line_next = shifter_next[0];
      ST_PARITY: line_next = par_bit_next;
      default:   line_next = 1'b1;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= ST_IDLE;
      cfg       <= '0;
      // NOTE: the data registers are reset too, so a mid-frame reset discards
      // the frame and buffer with no stale contents left behind.
      thr_data  <= '0;
      thr_full  <= 1'b0;
      shifter   <= '0;
      bit_cnt   <= '0;
      stop_ext  <= 1'b0;
      par_bit   <= 1'b0;
      txd_q     <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_next;
      shifter   <= shifter_next;
      bit_cnt   <= bit_cnt_next;
      stop_ext  <= stop_ext_next;
      par_bit   <= par_bit_next;
      txd_q     <= line_next;
      overrun_q <= bus.write_flag && thr_full && !load;
      if (load) cfg <= '{word_length: word_length, par_en: parity[PAR_EN], stop_bits: stop_bits};
      // A write in the load cycle refills the buffer while the old byte moves on.
      if (bus.write_flag) begin
        thr_data <= bus.tx_data;
        thr_full <= 1'b1;
      end else if (load) begin
        thr_full <= 1'b0;
      end
    end
  end

  assign bus.thr_empty  = !thr_full;
  assign bus.tx_empty   = !thr_full && (state == ST_IDLE);
  assign bus.tx_overrun = overrun_q;
  assign txd            = txd_q & ~set_break;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: hand-derived frame table, randomized frames
// against a bit-list reference model, plus back-to-back, overrun, break and reset.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int BAUD_W = 16;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [1:0]        word_length = 2'b11;
  logic [2:0]        parity = 3'b000;
  logic              stop_bits = 1'b0;
  logic              set_break = 1'b0;
  logic [BAUD_W-1:0] baud_rate_cnt = 16'd4;
  logic              txd;

  uart_tx_if bus ();

  uart_tx #(.BAUD_W(BAUD_W)) dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
    .bus           (bus.slave),
    .word_length   (word_length),
    .parity        (parity),
    .stop_bits     (stop_bits),
    .set_break     (set_break),
    .baud_rate_cnt (baud_rate_cnt),
    .txd           (txd)
  );

  always #5 PCLK = ~PCLK;

  int vectors    = 0;
  int miscompares = 0;
  int ov_count   = 0;
  bit exp_q[$];

  always @(negedge PCLK) if (bus.tx_overrun === 1'b1) ov_count++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference frame: one queue entry per PCLK cycle of expected line level.
  function automatic void model_frame(input logic [7:0] d, input logic [1:0] wl,
                                      input logic [2:0] par, input logic sb, input int baud);
    int p    = (baud < 1) ? 1 : baud;
    int n    = 5 + int'(wl);
    int ones = 0;
    bit pb;
    repeat (p) exp_q.push_back(1'b0);
    for (int i = 0; i < n; i++) begin
      ones += int'(d[i]);
      repeat (p) exp_q.push_back(d[i]);
    end
    if (par[0]) begin
      if (par[2])      pb = !par[1];
      else if (par[1]) pb = (ones % 2) == 1;
      else             pb = (ones % 2) == 0;
      repeat (p) exp_q.push_back(pb);
    end
    repeat (p) exp_q.push_back(1'b1);
    if (sb) repeat ((wl == 2'b00) ? baud / 2 : p) exp_q.push_back(1'b1);
  endfunction

  task automatic write_byte(input logic [7:0] d);
    @(posedge PCLK); #1;
    bus.tx_data    = d;
    bus.write_flag = 1'b1;
    @(posedge PCLK); #1;
    bus.write_flag = 1'b0;
  endtask

  task automatic play_queue(input string name);
    int cyc = 0;
    while (exp_q.size() > 0) begin
      bit b;
      b = exp_q.pop_front();
      @(negedge PCLK);
      check($sformatf("%s txd cyc %0d", name, cyc), 32'(txd), 32'(b & ~set_break));
      cyc++;
    end
    @(negedge PCLK);
    check({name, " tx_empty after stop"}, 32'(bus.tx_empty), 32'd1);
  endtask

  // Write, check C+1 status, then follow the frame cycle by cycle.
  task automatic launch(input logic [7:0] d, input string name, input bit scramble);
    write_byte(d);
    @(negedge PCLK);
    check({name, " thr_empty C+1"}, 32'(bus.thr_empty), 32'd0);
    check({name, " tx_empty C+1"},  32'(bus.tx_empty),  32'd0);
    check({name, " txd C+1"},       32'(txd),           32'd1);
    fork
      play_queue(name);
      begin
        @(posedge PCLK); #1;
        if (scramble) begin
          word_length = 2'($urandom_range(0, 3));
          parity      = 3'($urandom_range(0, 7));
          stop_bits   = 1'($urandom_range(0, 1));
        end
        @(negedge PCLK);
        check({name, " thr_empty C+2"}, 32'(bus.thr_empty), 32'd1);
      end
    join
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  wl;
    logic [2:0]  par;
    logic        sb;
    int          baud;
    logic [11:0] exp_bits;   // start, data, parity in line order from bit 0
    int          exp_nbits;
    int          exp_stop;   // stop-level cycles
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.tx_data    = 8'h00;
    bus.write_flag = 1'b0;

    tbl[0]  = '{8'hA5, 2'b11, 3'b000, 1'b0, 4, 12'b0001_0100_1010,  9, 4};
    tbl[1]  = '{8'h35, 2'b10, 3'b011, 1'b0, 3, 12'b0000_0110_1010,  9, 3};
    tbl[2]  = '{8'h35, 2'b00, 3'b001, 1'b1, 6, 12'b0000_0010_1010,  7, 9};
    tbl[3]  = '{8'h00, 2'b11, 3'b101, 1'b0, 2, 12'b0010_0000_0000, 10, 2};
    tbl[4]  = '{8'hFF, 2'b11, 3'b111, 1'b0, 1, 12'b0001_1111_1110, 10, 1};
    tbl[5]  = '{8'h2A, 2'b01, 3'b000, 1'b1, 3, 12'b0000_0101_0100,  7, 6};
    tbl[6]  = '{8'h01, 2'b11, 3'b000, 1'b0, 0, 12'b0000_0000_0010,  9, 1};
    tbl[7]  = '{8'h1F, 2'b00, 3'b000, 1'b1, 1, 12'b0000_0011_1110,  6, 1};
    tbl[8]  = '{8'hFF, 2'b11, 3'b101, 1'b0, 1, 12'b0011_1111_1110, 10, 1};
    tbl[9]  = '{8'h00, 2'b11, 3'b111, 1'b0, 1, 12'b0000_0000_0000, 10, 1};
    tbl[10] = '{8'h07, 2'b11, 3'b011, 1'b0, 2, 12'b0010_0000_1110, 10, 2};
    tbl[11] = '{8'h07, 2'b11, 3'b001, 1'b1, 2, 12'b0000_0000_1110, 10, 4};

    // Reset state
    #12;
    check("reset txd",        32'(txd),            32'd1);
    check("reset thr_empty",  32'(bus.thr_empty),  32'd1);
    check("reset tx_empty",   32'(bus.tx_empty),   32'd1);
    check("reset tx_overrun", 32'(bus.tx_overrun), 32'd0);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    repeat (2) @(negedge PCLK);
    check("idle txd", 32'(txd), 32'd1);

    // Hand-derived frame table
    for (int v = 0; v < 12; v++) begin
      int p;
      p = (tbl[v].baud < 1) ? 1 : tbl[v].baud;
      word_length   = tbl[v].wl;
      parity        = tbl[v].par;
      stop_bits     = tbl[v].sb;
      baud_rate_cnt = 16'(tbl[v].baud);
      for (int b = 0; b < tbl[v].exp_nbits; b++)
        repeat (p) exp_q.push_back(tbl[v].exp_bits[b]);
      repeat (tbl[v].exp_stop) exp_q.push_back(1'b1);
      launch(tbl[v].data, $sformatf("tbl%0d", v), 1'b0);
    end

    // Randomized frames against the model; LCR is scrambled mid-frame
    for (int r = 0; r < 24; r++) begin
      logic [7:0] d;
      int         baud;
      d             = 8'($urandom);
      baud          = int'($urandom_range(0, 5));
      word_length   = 2'($urandom_range(0, 3));
      parity        = 3'($urandom_range(0, 7));
      stop_bits     = 1'($urandom_range(0, 1));
      baud_rate_cnt = 16'(baud);
      model_frame(d, word_length, parity, stop_bits, baud);
      launch(d, $sformatf("rnd%0d", r), 1'b1);
    end

    // Back-to-back: second byte written during START, no idle gap
    word_length = 2'b11; parity = 3'b000; stop_bits = 1'b0; baud_rate_cnt = 16'd2;
    ov_count = 0;
    model_frame(8'h55, 2'b11, 3'b000, 1'b0, 2);
    model_frame(8'h0F, 2'b11, 3'b000, 1'b0, 2);
    write_byte(8'h55);
    @(negedge PCLK);
    fork
      play_queue("b2b");
      write_byte(8'h0F);
    join
    check("b2b no overrun", 32'(ov_count), 32'd0);

    // Overwrite before the second load: pulse overrun, newest byte wins
    ov_count = 0;
    model_frame(8'hC3, 2'b11, 3'b000, 1'b0, 2);
    model_frame(8'h81, 2'b11, 3'b000, 1'b0, 2);
    write_byte(8'hC3);
    @(negedge PCLK);
    fork
      play_queue("ovr");
      begin
        write_byte(8'h0F);
        repeat (5) @(posedge PCLK);
        write_byte(8'h81);
        @(negedge PCLK);
        check("ovr pulse C+1", 32'(bus.tx_overrun), 32'd1);
      end
    join
    check("ovr pulse count", 32'(ov_count), 32'd1);

    // Break mid-DATA, then resume at the right bit
    baud_rate_cnt = 16'd4;
    model_frame(8'hA5, 2'b11, 3'b000, 1'b0, 4);
    write_byte(8'hA5);
    @(negedge PCLK);
    fork
      play_queue("brk");
      begin
        repeat (14) @(posedge PCLK); #1;
        set_break = 1'b1;
        @(negedge PCLK);
        check("brk txd low", 32'(txd), 32'd0);
        repeat (6) @(posedge PCLK); #1;
        set_break = 1'b0;
      end
    join

    // Reset mid-frame with a byte waiting in the buffer
    write_byte(8'h00);
    write_byte(8'h99);
    repeat (12) @(negedge PCLK);
    check("rst pre txd low",   32'(txd),           32'd0);
    check("rst pre thr full",  32'(bus.thr_empty), 32'd0);
    #1 PRESETn = 1'b0;
    #1;
    check("rst txd",       32'(txd),           32'd1);
    check("rst thr_empty", 32'(bus.thr_empty), 32'd1);
    check("rst tx_empty",  32'(bus.tx_empty),  32'd1);
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge PCLK);
      check($sformatf("post-rst txd cyc %0d", c), 32'(txd), 32'd1);
    end
    check("post-rst tx_empty", 32'(bus.tx_empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
